// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: loads a parallel word, shifts it out LSB-first on ser_en,
// flags the last data bit and holds the word's parity for the TX mux.
module uart_tx_serializer #(
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  busy,
    input  logic                  ser_en,
    input  logic                  par_type,
    output logic                  ser_data,
    output logic                  ser_done,
    output logic                  par_bit
);
    localparam int CW = $clog2(data_width);
    localparam logic [CW-1:0] LAST = CW'(data_width - 1);
    logic [data_width-1:0] r_shift_reg;
    logic [CW-1:0]         r_bit_cnt;
    logic                  r_par_bit;
    logic                  w_load;
    assign w_load = data_valid & ~busy;
    // a load wins over a simultaneous shift enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift_reg <= '0;
            r_bit_cnt   <= '0;
            r_par_bit   <= 1'b0;
        end else if (w_load) begin
            r_shift_reg <= p_data;
            r_bit_cnt   <= '0;
            r_par_bit   <= ^p_data ^ par_type;
        end else if (ser_en) begin
            r_shift_reg <= {1'b0, r_shift_reg[data_width-1:1]};
            r_bit_cnt   <= (r_bit_cnt == LAST) ? '0 : r_bit_cnt + 1'b1;
        end
    end
    assign ser_data = r_shift_reg[0];
    assign ser_done = ser_en & (r_bit_cnt == LAST);
    assign par_bit  = r_par_bit;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed frames with a scoreboard queue checked by
// per-DUT monitors on every ser_en cycle; covers widths 8 and 5.
module tb_uart_tx_serializer;
    typedef struct packed {
        logic d;
        logic done;
        logic par;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] p_data = '0;
    logic       data_valid = 1'b0, busy = 1'b0, ser_en = 1'b0, par_type = 1'b0;
    logic       ser_data, ser_done, par_bit;
    logic [4:0] p5 = '0;
    logic       dv5 = 1'b0, en5 = 1'b0;
    logic       ser_data5, ser_done5, par_bit5;

    exp_t q[$];
    exp_t q5[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.data_width(8)) dut (
        .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid), .busy(busy),
        .ser_en(ser_en), .par_type(par_type), .ser_data(ser_data), .ser_done(ser_done),
        .par_bit(par_bit)
    );

    uart_tx_serializer #(.data_width(5)) dut5 (
        .clk(clk), .rst(rst), .p_data(p5), .data_valid(dv5), .busy(busy),
        .ser_en(en5), .par_type(par_type), .ser_data(ser_data5), .ser_done(ser_done5),
        .par_bit(par_bit5)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, " ser_data"}, ser_data, 1'b0);
        chk({name, " ser_done"}, ser_done, 1'b0);
        chk({name, " par_bit"}, par_bit, 1'b0);
    endtask

    // drive one cycle of the width-8 DUT; the width-5 DUT idles
    task automatic cyc(input logic v, input logic b, input logic e,
                       input logic [7:0] d, input logic pt);
        data_valid = v; busy = b; ser_en = e; p_data = d; par_type = pt;
        dv5 = 1'b0; en5 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc5(input logic v, input logic b, input logic e,
                        input logic [4:0] d, input logic pt);
        data_valid = 1'b0; ser_en = 1'b0; busy = b; par_type = pt;
        dv5 = v; en5 = e; p5 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic d, input logic done, input logic par);
        q.push_back('{d: d, done: done, par: par});
    endtask

    task automatic push5(input logic d, input logic done, input logic par);
        q5.push_back('{d: d, done: done, par: par});
    endtask

    always @(negedge clk) begin
        if (rst && ser_en) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL w8 unexpected shift: got ser_data=%b ser_done=%b, expected no shift",
                         ser_data, ser_done);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("w8 ser_data", ser_data, e.d);
                chk("w8 ser_done", ser_done, e.done);
                chk("w8 par_bit", par_bit, e.par);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && en5) begin
            if (q5.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL w5 unexpected shift: got ser_data=%b ser_done=%b, expected no shift",
                         ser_data5, ser_done5);
            end else begin
                exp_t e;
                e = q5.pop_front();
                chk("w5 ser_data", ser_data5, e.d);
                chk("w5 ser_done", ser_done5, e.done);
                chk("w5 par_bit", par_bit5, e.par);
            end
        end
    end

    initial begin
        logic [0:7]  e8;
        logic [0:10] pat;
        logic [0:4]  e5;
        int k;

        // 1: reset with random inputs, then hold after release
        for (int i = 0; i < 2; i++) begin
            data_valid = 1'($urandom); busy = 1'($urandom); ser_en = 1'($urandom);
            p_data = 8'($urandom); par_type = 1'($urandom);
            @(negedge clk);
            chk_zero("reset");
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 8'h5A, 1'b1);
            chk_zero("post-reset hold");
        end

        // 2: A5 even parity, contiguous, then wrap shifts zeros
        cyc(1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);
        e8 = 8'b1010_0101;
        for (int i = 0; i < 8; i++) begin
            push(e8[i], i == 7, 1'b0);
            cyc(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            push(1'b0, i == 7, 1'b0);
            cyc(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // 3: 03 odd parity, gapped enables
        cyc(1'b1, 1'b0, 1'b0, 8'h03, 1'b1);
        pat = 11'b1_0_1_1_0_0_1_1_1_1_1;
        e8 = 8'b1100_0000;
        k = 0;
        for (int j = 0; j < 11; j++) begin
            if (pat[j]) begin
                push(e8[k], k == 7, 1'b1);
                k++;
            end
            cyc(1'b0, 1'b1, pat[j], 8'h00, 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // 4: load attempt while busy mid-frame is ignored
        cyc(1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);
        e8 = 8'b1010_0101;
        for (int i = 0; i < 3; i++) begin
            push(e8[i], 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b1);
        for (int i = 3; i < 8; i++) begin
            push(e8[i], i == 7, 1'b0);
            cyc(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // 5: async reset mid-frame, then reload 81
        cyc(1'b1, 1'b0, 1'b0, 8'hF0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        end
        chk("pre-reset par_bit", par_bit, 1'b1);
        #2 rst = 1'b0;
        #1 chk_zero("mid-frame reset");
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            chk_zero("post mid-frame reset");
        end
        cyc(1'b1, 1'b0, 1'b0, 8'h81, 1'b0);
        e8 = 8'b1000_0001;
        for (int i = 0; i < 8; i++) begin
            push(e8[i], i == 7, 1'b0);
            cyc(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // 6: width 5, 10110 even parity, then wrap
        cyc5(1'b1, 1'b0, 1'b0, 5'b10110, 1'b0);
        e5 = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            push5(e5[i], i == 4, 1'b1);
            cyc5(1'b0, 1'b1, 1'b1, 5'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            push5(1'b0, i == 4, 1'b1);
            cyc5(1'b0, 1'b1, 1'b1, 5'b0, 1'b0);
        end
        cyc5(1'b0, 1'b0, 1'b0, 5'b0, 1'b0);

        repeat (2) @(posedge clk);
        tests++;
        if (q.size() + q5.size() != 0) begin
            fails++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size() + q5.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Datapath partner of the UART TX control FSM. It captures the parallel byte when a transfer is accepted and shifts it out LSB-first, one bit per cycle of `ser_en`. It asserts `ser_done` on the final data bit so the FSM can move to the parity or stop state. It also computes and holds the parity bit that the TX output mux selects.

Parameters:
- data_width, 8, number of data bits per frame (2..16).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset; 0 = reset.
- p_data  input  data_width  parallel data from the host.
- data_valid  input  1  host strobe; `p_data` is valid this cycle.
- busy  input  1  from the TX FSM; high while a frame is in progress.
- ser_en  input  1  from the TX FSM; shift-enable during the data state.
- par_type  input  1  0 = even parity, 1 = odd parity; sampled at load.
- ser_data  output  1  current serial data bit, to the TX mux.
- ser_done  output  1  last data bit is being sent this cycle.
- par_bit  output  1  parity of the latched word, to the TX mux.

Behaviour:
- Reset (`rst`=0, async): `shift_reg`=0, `bit_cnt`=0, `par_bit`=0. Consequently `ser_data`=0 and `ser_done`=0.
- Internal state:
  - `shift_reg[data_width-1:0]`.
  - `bit_cnt`, width `$clog2(data_width)`.
  - `par_bit` register.
- Load:
  - Condition: `data_valid`=1 AND `busy`=0 at a rising edge.
  - `shift_reg` <= `p_data`; `bit_cnt` <= 0.
  - `par_bit` <= (^`p_data`) XOR `par_type`.
  - Values are visible the cycle after the edge.
- Load has priority over shift. If `ser_en`=1 in the same cycle (illegal from the FSM), the shift is ignored.
- `data_valid` while `busy`=1 is ignored. `shift_reg`, `bit_cnt` and `par_bit` are unchanged.
- Shift:
  - Condition: `ser_en`=1 and no load.
  - `shift_reg` <= {1'b0, `shift_reg[data_width-1:1]`}.
  - `bit_cnt` <= `bit_cnt`+1, or 0 if `bit_cnt`==data_width-1 (wrap).
- Hold: `ser_en`=0 and no load leaves all registers unchanged. Gaps in `ser_en` are legal and stall serialization.
- `ser_data` = `shift_reg[0]` (registered source, no combinational path from inputs). Bit i of the loaded word appears on `ser_data` during the (i+1)-th `ser_en` cycle.
- `ser_done` = `ser_en` AND (`bit_cnt`==data_width-1). This is a combinational one-cycle pulse coincident with the last data bit; the FSM samples it on the same edge that ends that bit.
- After wrap: `bit_cnt`=0 and `shift_reg`=0. Further `ser_en` without a new load shifts zeros and pulses `ser_done` again every data_width enables. This is defined behaviour and not an error.
- `par_bit` is stable from the cycle after load until the next load or reset. It is independent of shifting.
- Reset asserted mid-frame clears all state immediately. After release, no output toggles until the next load.

Test Plan:
1. Reset check: `rst`=0 for 2 cycles with random inputs → `ser_data`=0, `ser_done`=0, `par_bit`=0 throughout. Release → values hold until a load.
2. Even parity, contiguous shift:
   - Stimulus: `p_data`=8'hA5, `par_type`=0, `data_valid`=1, `busy`=0 for one cycle; then `busy`=1 and `ser_en`=1 for 8 cycles.
   - Response: `ser_data` sequence 1,0,1,0,0,1,0,1; `ser_done`=1 only in the 8th cycle; `par_bit`=0.
3. Odd parity, gapped `ser_en`:
   - Stimulus: `p_data`=8'h03, `par_type`=1; `ser_en` pattern 1,0,1,1,0,0,1,1,1,1,1.
   - Response: bits 1,1,0,0,0,0,0,0 delivered only on enabled cycles; `ser_done` on the 8th enable; `par_bit`=1.
4. Load while busy: mid-frame of 8'hA5, drive `data_valid`=1 with `p_data`=8'hFF and `busy`=1 → remaining bits stay from 8'hA5; `par_bit` unchanged at 0.
5. Reset mid-frame: after 3 shifts of 8'hF0, pulse `rst`=0 → all outputs 0 immediately. Reload 8'h81 → `ser_data` sequence 1,0,0,0,0,0,0,1 with `ser_done` on the 8th enable.
6. Parameter sweep: data_width=5, `p_data`=5'b10110, `par_type`=0 → bits 0,1,1,0,1; `ser_done` on the 5th enable; `par_bit`=1.
